// File: rtl/taillight_seq_monitor_if.sv
// Lamp-bus checker port bundle: sampled lamp codes and clear in, status and diagnostics out.
// master drives the lamp bus and Clr; slave is the monitor.
interface taillight_seq_monitor_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       Left;
  logic [2:0]       Right;
  logic             Clr;
  logic [1:0]       Dir;
  logic [CNT_W-1:0] Left_sweeps;
  logic [CNT_W-1:0] Right_sweeps;
  logic [1:0]       Seq_err;
  logic [1:0]       Stuck;
  logic             Both_err;

  modport master (
    output Left, Right, Clr,
    input  Dir, Left_sweeps, Right_sweeps, Seq_err, Stuck, Both_err
  );

  modport slave (
    input  Left, Right, Clr,
    output Dir, Left_sweeps, Right_sweeps, Seq_err, Stuck, Both_err
  );
endinterface

// File: rtl/taillight_seq_monitor.sv
// Tail-light lamp bus checker: direction decode, sweep counts, sticky sequence/stuck/both faults.
// Outputs move one Clk after a code is sampled into the input register; no backpressure, samples every Clk.
module taillight_seq_monitor #(
  parameter int STUCK_CYC = 134217728,
  parameter int IDLE_CYC  = 134217728,
  parameter int CNT_W     = 8,
  parameter int TMR_W     = 28
) (
  input  logic                   Clk,
  input  logic                   Rst,
  taillight_seq_monitor_if.slave bus
);

  typedef enum logic [1:0] {S_OFF, S_1, S_2, S_3} state_t;

  localparam logic [TMR_W-1:0] STUCK_LAST = TMR_W'(STUCK_CYC - 1);
  localparam logic [TMR_W-1:0] IDLE_LAST  = TMR_W'(IDLE_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_MAX    = '1;

  // Index 1 is the left side, index 0 the right, matching the {left, right} output packing.
  logic [2:0]       code_q      [2];
  logic [2:0]       code_prev_q [2];
  state_t           state_q     [2];
  state_t           state_d     [2];
  logic [CNT_W-1:0] sweeps_q    [2];
  logic [CNT_W-1:0] sweeps_d    [2];
  logic [TMR_W-1:0] stuck_tmr_q [2];
  logic [TMR_W-1:0] stuck_tmr_d [2];
  logic [TMR_W-1:0] idle_tmr_q  [2];
  logic [TMR_W-1:0] idle_tmr_d  [2];
  logic [1:0]       active_q, active_d;
  logic [1:0]       seq_fault, stuck_fault;
  logic [1:0]       seq_err_q, seq_err_d;
  logic [1:0]       stuck_q, stuck_d;
  logic             both_err_q, both_err_d;

  function automatic logic is_legal(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b001) || (c == 3'b011) || (c == 3'b111);
  endfunction

  function automatic state_t code_to_state(input logic [2:0] c);
    case (c)
      3'b001:  return S_1;
      3'b011:  return S_2;
      3'b111:  return S_3;
      default: return S_OFF;
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      S_OFF:   return S_1;
      S_1:     return S_2;
      S_2:     return S_3;
      default: return S_OFF;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int s = 0; s < 2; s++) begin
        code_q[s]      <= '0;
        code_prev_q[s] <= '0;
        state_q[s]     <= S_OFF;
        sweeps_q[s]    <= '0;
        stuck_tmr_q[s] <= '0;
        idle_tmr_q[s]  <= '0;
      end
      active_q   <= '0;
      seq_err_q  <= '0;
      stuck_q    <= '0;
      both_err_q <= 1'b0;
    end else begin
      code_q[1] <= bus.Left;
      code_q[0] <= bus.Right;
      for (int s = 0; s < 2; s++) begin
        code_prev_q[s] <= code_q[s];
        state_q[s]     <= state_d[s];
        sweeps_q[s]    <= sweeps_d[s];
        stuck_tmr_q[s] <= stuck_tmr_d[s];
        idle_tmr_q[s]  <= idle_tmr_d[s];
      end
      active_q   <= active_d;
      seq_err_q  <= seq_err_d;
      stuck_q    <= stuck_d;
      both_err_q <= both_err_d;
    end
  end

  always_comb begin
    active_d    = active_q;
    seq_fault   = '0;
    stuck_fault = '0;
    for (int s = 0; s < 2; s++) begin
      state_d[s]     = state_q[s];
      sweeps_d[s]    = sweeps_q[s];
      stuck_tmr_d[s] = stuck_tmr_q[s];
      idle_tmr_d[s]  = idle_tmr_q[s];

      // A return to 000 is always allowed; only S_3 -> S_OFF counts as a finished sweep.
      if (!is_legal(code_q[s])) begin
        seq_fault[s] = 1'b1;
        state_d[s]   = S_OFF;
      end else begin
        state_d[s] = code_to_state(code_q[s]);
        if (code_to_state(code_q[s]) == S_OFF) begin
          if (state_q[s] == S_3)
            sweeps_d[s] = sweeps_q[s] + 1'b1;
        end else if ((code_to_state(code_q[s]) != state_q[s]) &&
                     (code_to_state(code_q[s]) != succ(state_q[s]))) begin
          seq_fault[s] = 1'b1;
        end
      end

      if ((code_q[s] != code_prev_q[s]) || (code_q[s] == 3'b000)) begin
        stuck_tmr_d[s] = '0;
      end else begin
        if (stuck_tmr_q[s] == STUCK_LAST)
          stuck_fault[s] = 1'b1;
        if (stuck_tmr_q[s] != TMR_MAX)
          stuck_tmr_d[s] = stuck_tmr_q[s] + 1'b1;
      end

      // The idle delay keeps Dir steady through the 000 phase of a running sweep.
      if (code_q[s] != 3'b000) begin
        idle_tmr_d[s] = '0;
        active_d[s]   = 1'b1;
      end else begin
        if (idle_tmr_q[s] == IDLE_LAST)
          active_d[s] = 1'b0;
        if (idle_tmr_q[s] != TMR_MAX)
          idle_tmr_d[s] = idle_tmr_q[s] + 1'b1;
      end
    end

    seq_err_d  = (seq_err_q & ~{2{bus.Clr}}) | seq_fault;
    stuck_d    = (stuck_q & ~{2{bus.Clr}}) | stuck_fault;
    both_err_d = (both_err_q & ~bus.Clr) | (&active_d);
  end

  assign bus.Dir          = active_q;
  assign bus.Left_sweeps  = sweeps_q[1];
  assign bus.Right_sweeps = sweeps_q[0];
  assign bus.Seq_err      = seq_err_q;
  assign bus.Stuck        = stuck_q;
  assign bus.Both_err     = both_err_q;

endmodule

// File: tb/tb_taillight_seq_monitor.sv
// Directed bench for the lamp-bus checker with short stuck/idle windows.
// Inputs change and outputs are sampled 1 time unit after each rising Clk edge.
module tb_taillight_seq_monitor;

  logic Clk = 1'b0;
  logic Rst;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  taillight_seq_monitor_if #(.CNT_W(8)) bus ();

  taillight_seq_monitor #(
    .STUCK_CYC(16),
    .IDLE_CYC (16),
    .CNT_W    (8),
    .TMR_W    (28)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic right_sweep_fast();
    bus.Right = 3'b001; tick(1);
    bus.Right = 3'b011; tick(1);
    bus.Right = 3'b111; tick(1);
    bus.Right = 3'b000; tick(1);
  endtask

  initial begin
    logic [2:0] steps [4];
    steps[0] = 3'b001; steps[1] = 3'b011; steps[2] = 3'b111; steps[3] = 3'b000;

    Rst = 1'b1; bus.Left = 3'b000; bus.Right = 3'b000; bus.Clr = 1'b0;
    tick(3);
    Rst = 1'b0;

    // Reset state
    chk("rst_dir",      32'(bus.Dir), 32'd0);
    chk("rst_seq_err",  32'(bus.Seq_err), 32'd0);
    chk("rst_stuck",    32'(bus.Stuck), 32'd0);
    chk("rst_both",     32'(bus.Both_err), 32'd0);
    chk("rst_lsweeps",  32'(bus.Left_sweeps), 32'd0);
    chk("rst_rsweeps",  32'(bus.Right_sweeps), 32'd0);

    // Three clean right sweeps, 4 cycles per code
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++) begin
        bus.Right = steps[k];
        tick(4);
      end
    chk("sweep3_count", 32'(bus.Right_sweeps), 32'd3);
    chk("sweep3_dir",   32'(bus.Dir), 32'd1);
    chk("sweep3_seq",   32'(bus.Seq_err), 32'd0);
    chk("sweep3_stuck", 32'(bus.Stuck), 32'd0);
    tick(12);
    chk("idle_hold_dir", 32'(bus.Dir), 32'd1);
    tick(1);
    chk("idle_drop_dir", 32'(bus.Dir), 32'd0);

    // Left skips 011: illegal step
    bus.Left = 3'b001; tick(4);
    bus.Left = 3'b111; tick(1);
    chk("skip_pre_err", 32'(bus.Seq_err), 32'd0);
    tick(1);
    chk("skip_err",     32'(bus.Seq_err), 32'd2);
    chk("skip_lsweeps", 32'(bus.Left_sweeps), 32'd0);
    chk("skip_dir",     32'(bus.Dir), 32'd2);
    bus.Clr = 1'b1; tick(1); bus.Clr = 1'b0;
    chk("clr1_seq", 32'(bus.Seq_err), 32'd0);

    // Illegal code 010 forces S_OFF, so the following 000 is not a sweep
    bus.Left = 3'b010; tick(2);
    chk("bad_code_err", 32'(bus.Seq_err), 32'd2);
    bus.Left = 3'b000; tick(3);
    chk("bad_code_nosweep", 32'(bus.Left_sweeps), 32'd0);
    bus.Clr = 1'b1; tick(1); bus.Clr = 1'b0;
    chk("clr2_seq", 32'(bus.Seq_err), 32'd0);
    tick(20);
    chk("left_idle_dir", 32'(bus.Dir), 32'd0);

    // Stuck right lamp at 011
    bus.Right = 3'b001; tick(4);
    bus.Right = 3'b011; tick(17);
    chk("stuck_pre",  32'(bus.Stuck), 32'd0);
    tick(1);
    chk("stuck_set",  32'(bus.Stuck), 32'd1);
    chk("stuck_seq",  32'(bus.Seq_err), 32'd0);
    chk("stuck_dir",  32'(bus.Dir), 32'd1);
    tick(2);
    bus.Clr = 1'b1; tick(1); bus.Clr = 1'b0;
    chk("stuck_clr",  32'(bus.Stuck), 32'd0);
    bus.Right = 3'b111; tick(2);
    bus.Right = 3'b000; tick(2);
    bus.Right = 3'b001; tick(12);
    chk("short_hold_stuck", 32'(bus.Stuck), 32'd0);
    chk("short_hold_seq",   32'(bus.Seq_err), 32'd0);
    chk("stuck_rsweeps",    32'(bus.Right_sweeps), 32'd4);

    // Both sides active
    bus.Left = 3'b001; tick(1);
    chk("both_pre", 32'(bus.Both_err), 32'd0);
    tick(1);
    chk("both_dir", 32'(bus.Dir), 32'd3);
    chk("both_err", 32'(bus.Both_err), 32'd1);

    // Right sweep counter wrap: 4 -> 255 -> 0
    bus.Left = 3'b000;
    bus.Right = 3'b011; tick(1);
    bus.Right = 3'b111; tick(1);
    bus.Right = 3'b000; tick(1);
    for (int i = 0; i < 250; i++) right_sweep_fast();
    tick(2);
    chk("wrap_255", 32'(bus.Right_sweeps), 32'd255);
    right_sweep_fast();
    tick(2);
    chk("wrap_0",       32'(bus.Right_sweeps), 32'd0);
    chk("wrap_seq",     32'(bus.Seq_err), 32'd0);
    chk("wrap_lsweeps", 32'(bus.Left_sweeps), 32'd0);

    // Reset mid-sweep, then 011 is an illegal step from S_OFF
    bus.Right = 3'b001; tick(2);
    bus.Right = 3'b011; tick(2);
    Rst = 1'b1; tick(1); Rst = 1'b0;
    chk("midrst_seq",     32'(bus.Seq_err), 32'd0);
    chk("midrst_both",    32'(bus.Both_err), 32'd0);
    chk("midrst_rsweeps", 32'(bus.Right_sweeps), 32'd0);
    chk("midrst_dir",     32'(bus.Dir), 32'd0);
    tick(1);
    chk("midrst_seq_pre", 32'(bus.Seq_err), 32'd0);
    tick(1);
    chk("midrst_seq_err", 32'(bus.Seq_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
